// File: rtl/sbqm_pkg.sv
// sbqm_pkg -- shared definitions for the bank queue controller.
//   div_state_t : states of the wait-time divider FSM
//   PCOUNT_W()  : width needed to hold a people count 0..MAX_PEOPLE
//   DIV_W()     : width of the wait-time dividend WAIT_UNIT*(p+t-1)
package sbqm_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic int PCOUNT_W(input int max_people);
        return $clog2(max_people + 1);
    endfunction

    // Largest dividend is WAIT_UNIT*(MAX_PEOPLE + max_tellers - 1).
    // Kept at least 2 bits wide so the quotient shift register always has
    // a distinct MSB and body.
    function automatic int DIV_W(input int max_people, input int teller_w,
                                 input int wait_unit);
        int max_dividend;
        int w;
        max_dividend = wait_unit * (max_people + (1 << teller_w) - 2);
        w = $clog2(max_dividend + 1);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/sbqm_wait_div.sv
// sbqm_wait_div -- sequential wait-time estimator.
// Computes w_time = floor(WAIT_UNIT*(p_count+t_count-1)/t_count) with a
// restoring divider (one quotient bit per cycle), saturating to WAIT_W bits.
// p_count==0 gives 0, t_count==0 (with people waiting) gives all-ones; both
// skip the division entirely.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   p_count [PW-1:0]  : current queue occupancy
//   t_count [TW-1:0]  : open tellers
//   w_time  [WW-1:0]  : latest completed estimate
//   w_valid           : w_time corresponds to the present p_count/t_count
module sbqm_wait_div
    import sbqm_pkg::*;
#(
    parameter int MAX_PEOPLE = 7,
    parameter int TELLER_W   = 2,
    parameter int WAIT_UNIT  = 3,
    parameter int WAIT_W     = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PCOUNT_W(MAX_PEOPLE)-1:0]  p_count,
    input  logic [TELLER_W-1:0]              t_count,
    output logic [WAIT_W-1:0]                w_time,
    output logic                             w_valid
);

    localparam int PW = PCOUNT_W(MAX_PEOPLE);
    localparam int DW = DIV_W(MAX_PEOPLE, TELLER_W, WAIT_UNIT);
    localparam int CW = $clog2(DW + 1);
    localparam int SW = (DW > WAIT_W) ? DW : WAIT_W;

    div_state_t state_reg, state_next;

    logic [PW-1:0]       last_p_reg;
    logic [TELLER_W-1:0] last_t_reg;
    logic [PW-1:0]       op_p_reg;
    logic [TELLER_W-1:0] op_t_reg;
    logic [DW-1:0]       quo_reg;
    logic [TELLER_W-1:0] rem_reg;
    logic [CW-1:0]       cnt_reg;
    logic                pending_reg;
    logic                valid_reg;
    logic [WAIT_W-1:0]   w_time_reg;

    logic                change;
    logic                special;
    logic                start;
    logic                finish;
    logic [DW-1:0]       dividend;
    logic [TELLER_W:0]   rem_shift;
    logic [TELLER_W:0]   divisor_ext;
    logic                rem_ge;
    logic [SW-1:0]       quo_ext;
    logic [SW-1:0]       sat_max;
    logic [WAIT_W-1:0]   result;

    // Operands differ from what was seen last cycle.
    assign change  = (p_count != last_p_reg) || (t_count != last_t_reg);
    assign special = (p_count == '0) || (t_count == '0);
    // Only used when p_count>=1, so p+t-1 cannot underflow.
    assign dividend = DW'(WAIT_UNIT) * (DW'(p_count) + DW'(t_count) - DW'(1));

    assign rem_shift   = {rem_reg, quo_reg[DW-1]};
    assign divisor_ext = {1'b0, op_t_reg};
    assign rem_ge      = (rem_shift >= divisor_ext);

    always_comb begin
        sat_max = '0;
        sat_max[WAIT_W-1:0] = '1;
        quo_ext = SW'(quo_reg);
        if (op_p_reg == '0) begin
            result = '0;
        end else if (op_t_reg == '0) begin
            result = '1;
        end else if (quo_ext > sat_max) begin
            result = '1;
        end else begin
            result = quo_ext[WAIT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= DIV_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            DIV_IDLE: begin
                if (change) begin
                    start      = 1'b1;
                    state_next = special ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (cnt_reg == CW'(DW - 1)) begin
                    state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                // Operands moved while dividing: the quotient is stale, redo it.
                if (pending_reg || change) begin
                    start      = 1'b1;
                    state_next = special ? DIV_DONE : DIV_BUSY;
                end else begin
                    finish     = 1'b1;
                    state_next = DIV_IDLE;
                end
            end
            default: state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_p_reg  <= '0;
            // Track t_count through reset so leaving reset does not look
            // like an operand change.
            last_t_reg  <= t_count;
            op_p_reg    <= '0;
            op_t_reg    <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
            valid_reg   <= 1'b1;
            w_time_reg  <= '0;
        end else begin
            last_p_reg <= p_count;
            last_t_reg <= t_count;
            if (start) begin
                op_p_reg    <= p_count;
                op_t_reg    <= t_count;
                quo_reg     <= special ? '0 : dividend;
                rem_reg     <= '0;
                cnt_reg     <= '0;
                pending_reg <= 1'b0;
                valid_reg   <= 1'b0;
            end else if (state_reg == DIV_BUSY) begin
                quo_reg <= {quo_reg[DW-2:0], rem_ge};
                rem_reg <= rem_ge ? TELLER_W'(rem_shift - divisor_ext)
                                  : TELLER_W'(rem_shift);
                cnt_reg <= cnt_reg + CW'(1);
                if (change) begin
                    pending_reg <= 1'b1;
                end
            end
            if (finish) begin
                w_time_reg <= result;
                valid_reg  <= 1'b1;
            end
        end
    end

    assign w_time = w_time_reg;
    // The cycle an operand changes the held estimate is already stale.
    assign w_valid = valid_reg && !change;

endmodule

// File: rtl/bank_queue_ctrl.sv
// bank_queue_ctrl -- single-queue bank occupancy counter with wait estimate.
// Back sensor a (arrival) and front sensor b (departure) are idle-high and
// asynchronous; each goes through a 2-flop synchroniser and a falling-edge
// detector. Occupancy, empty/full flags and sticky error flags are kept
// here; the wait-time estimate comes from sbqm_wait_div.
// Optional: define SBQM_STATS_EN to add served_cnt/arrived_cnt counters.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   a, b                 : arrival / departure sensors (async, idle high)
//   t_count [TELLER_W]   : number of open tellers
//   p_count              : people in queue
//   empty_flag/full_flag : p_count==0 / p_count==MAX_PEOPLE
//   w_time, w_valid      : wait estimate and its validity
//   ovf_err, unf_err     : sticky arrival-while-full / departure-while-empty
//   served_cnt, arrived_cnt [15:0] : (SBQM_STATS_EN only) accepted events
module bank_queue_ctrl
    import sbqm_pkg::*;
#(
    parameter int MAX_PEOPLE = 7,
    parameter int TELLER_W   = 2,
    parameter int WAIT_UNIT  = 3,
    parameter int WAIT_W     = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             a,
    input  logic                             b,
    input  logic [TELLER_W-1:0]              t_count,
    output logic [PCOUNT_W(MAX_PEOPLE)-1:0]  p_count,
    output logic                             empty_flag,
    output logic                             full_flag,
    output logic [WAIT_W-1:0]                w_time,
    output logic                             w_valid,
    output logic                             ovf_err,
`ifdef SBQM_STATS_EN
    output logic [15:0]                      served_cnt,
    output logic [15:0]                      arrived_cnt,
`endif
    output logic                             unf_err
);

    localparam int PW = PCOUNT_W(MAX_PEOPLE);

    logic [1:0]    sens;
    logic [1:0]    fall;
    logic          arr;
    logic          dep;
    logic [PW-1:0] p_reg, p_next;
    logic          empty_reg, full_reg;
    logic          ovf_reg, unf_reg;
    logic          ovf_set, unf_set;

    assign sens = {b, a};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sens
            logic sync1_reg, sync2_reg, prev_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    prev_reg  <= 1'b1;
                end else begin
                    sync1_reg <= sens[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                end
            end
            assign fall[gi] = prev_reg & ~sync2_reg;
        end
    endgenerate

    assign arr = fall[0];
    assign dep = fall[1];

    // Simultaneous arrival and departure always leaves the count unchanged
    // and never raises an error, whatever the occupancy.
    always_comb begin
        p_next  = p_reg;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case ({arr, dep})
            2'b10: begin
                if (full_reg) ovf_set = 1'b1;
                else          p_next  = p_reg + PW'(1);
            end
            2'b01: begin
                if (empty_reg) unf_set = 1'b1;
                else           p_next  = p_reg - PW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_reg     <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            p_reg     <= p_next;
            empty_reg <= (p_next == '0);
            full_reg  <= (p_next == PW'(MAX_PEOPLE));
            if (ovf_set) ovf_reg <= 1'b1;
            if (unf_set) unf_reg <= 1'b1;
        end
    end

`ifdef SBQM_STATS_EN
    logic [15:0] served_reg, arrived_reg;
    always_ff @(posedge clk) begin
        if (reset) begin
            served_reg  <= '0;
            arrived_reg <= '0;
        end else begin
            if (arr && (dep || !full_reg))  arrived_reg <= arrived_reg + 16'd1;
            if (dep && (arr || !empty_reg)) served_reg  <= served_reg + 16'd1;
        end
    end
    assign served_cnt  = served_reg;
    assign arrived_cnt = arrived_reg;
`endif

    assign p_count    = p_reg;
    assign empty_flag = empty_reg;
    assign full_flag  = full_reg;
    assign ovf_err    = ovf_reg;
    assign unf_err    = unf_reg;

    sbqm_wait_div #(
        .MAX_PEOPLE (MAX_PEOPLE),
        .TELLER_W   (TELLER_W),
        .WAIT_UNIT  (WAIT_UNIT),
        .WAIT_W     (WAIT_W)
    ) u_wait_div (
        .clk     (clk),
        .reset   (reset),
        .p_count (p_reg),
        .t_count (t_count),
        .w_time  (w_time),
        .w_valid (w_valid)
    );

endmodule

// File: doc/bank_queue_ctrl.md
BANK_QUEUE_CTRL -- requirements
Module: bank_queue_ctrl

Interface
REQ-001 Parameter MAX_PEOPLE, default 7: queue capacity; legal range 1..255.
REQ-002 Parameter TELLER_W, default 2: width of the teller-count input.
REQ-003 Parameter WAIT_UNIT, default 3: time units each served person adds per teller.
REQ-004 Parameter WAIT_W, default 5: wait-time output width.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port a, input, 1: back sensor (arrival); asynchronous to clk.
REQ-008 Port b, input, 1: front sensor (departure); asynchronous to clk.
REQ-009 Port t_count, input, TELLER_W: number of open tellers; treated as quasi-static.
REQ-010 Port p_count, output, clog2(MAX_PEOPLE+1): people currently in the queue.
REQ-011 Port empty_flag, output, 1: p_count==0.
REQ-012 Port full_flag, output, 1: p_count==MAX_PEOPLE.
REQ-013 Port w_time, output, WAIT_W: estimated wait time.
REQ-014 Port w_valid, output, 1: w_time matches the current p_count and t_count.
REQ-015 Port ovf_err, output, 1: sticky flag, arrival attempted while full.
REQ-016 Port unf_err, output, 1: sticky flag, departure attempted while empty.

Function
REQ-017 Each of a and b shall pass through a 2-flop synchroniser, then a falling-edge detector that emits a 1-cycle event pulse.
REQ-018 p_count shall change on the 3rd rising clk edge after the sensor is first sampled low.
REQ-019 Arrival only, p_count<MAX_PEOPLE: p_count increments by 1.
REQ-020 Arrival only, queue full: p_count holds and ovf_err sets.
REQ-021 Departure only, p_count>0: p_count decrements by 1.
REQ-022 Departure only, queue empty: p_count holds and unf_err sets.
REQ-023 Arrival and departure in the same cycle with 0<p_count<MAX_PEOPLE: p_count holds.
REQ-024 Arrival and departure in the same cycle at empty: p_count holds and no error flag sets.
REQ-025 Arrival and departure in the same cycle at full: p_count holds and no error flag sets.
REQ-026 empty_flag and full_flag shall be registered and valid in the same cycle p_count takes its new value.
REQ-027 Wait time: w_time = (WAIT_UNIT*(p_count+t_count-1)) / t_count, integer floor, computed at full internal width.
REQ-028 w_time shall be 0 when p_count==0.
REQ-029 w_time shall saturate to all-ones if the result exceeds WAIT_W bits.
REQ-030 t_count==0 with p_count>0: w_time = all-ones with w_valid=1, and no division is performed.
REQ-031 The divider FSM has three states.
REQ-032 FSM state IDLE: on a change of p_count or t_count, capture the operands, drop w_valid and go to BUSY.
REQ-033 FSM state BUSY: restoring division, one quotient bit per cycle, for DIV_W cycles, then go to DONE.
REQ-034 FSM state DONE: load w_time, set w_valid for one cycle of DONE, then return to IDLE.
REQ-035 An operand change while in BUSY shall set a pending bit; on completion the FSM restarts instead of asserting w_valid.
REQ-036 w_valid shall never be high while w_time is stale.

Reset
REQ-037 On reset: p_count=0, empty_flag=1, full_flag=0, w_time=0, w_valid=1, ovf_err=0, unf_err=0.
REQ-038 On reset: synchroniser flops=1 (sensor idle-high), FSM=IDLE, pending bit=0.
REQ-039 Reset asserted mid-division shall abort the division immediately.
REQ-040 A sensor edge in the reset cycle shall be ignored.
REQ-041 ovf_err and unf_err shall clear only on reset.

Configuration
REQ-042 With SBQM_STATS_EN defined, the block adds outputs served_cnt[15:0] and arrived_cnt[15:0].
REQ-043 served_cnt counts accepted departures and arrived_cnt counts accepted arrivals; both wrap at 2^16 and clear on reset.
REQ-044 Without SBQM_STATS_EN, served_cnt and arrived_cnt and their logic are absent.

Structure
REQ-045 Package sbqm_pkg shall hold: the divider FSM state enum, and the PCOUNT_W and DIV_W width functions.
REQ-046 The sequential divider shall be a separate sub-module, sbqm_wait_div.
REQ-047 Synchronisers and edge detectors shall be inline in bank_queue_ctrl.

Verification
REQ-048 Five arrival pulses on a, t_count=2: p_count=5 at the 3rd edge after the last pulse; w_valid then rises; w_time=9.
REQ-049 Eight arrivals with MAX_PEOPLE=7: p_count=7, full_flag=1, ovf_err=1.
REQ-050 b pulse at empty: p_count=0, unf_err=1; then a and b falling in the same cycle at p_count=3: p_count stays 3.
REQ-051 t_count changed from 1 to 3 mid-BUSY with p_count=4: w_valid stays low until the restarted division ends, then w_time=6.
REQ-052 t_count=0 with p_count=2: w_time=31, w_valid=1; reset asserted mid-division: all outputs match REQ-037 on the next cycle.
